// File: rtl/ssi_encoder_emulator_if.sv
// Register-write bus from the SPI slave into the SSI encoder emulator.
interface ssi_encoder_emulator_if;
  logic [31:0] data_mosi;
  logic        data_mosi_rdy;
  logic [15:0] addr;

  modport master (
    output data_mosi,
    output data_mosi_rdy,
    output addr
  );

  modport slave (
    input data_mosi,
    input data_mosi_rdy,
    input addr
  );
endinterface

// File: rtl/ssi_encoder_emulator.sv
// SSI slave emulating the absolute encoder: shifts a 44-bit frame
// {header, position, err, warn, ~crc6} out on ssi_d, clocked by the master's ssi_c.
module ssi_encoder_emulator #(
  parameter logic [15:0] ADDR_EMU_POSITION = 16'h0040,
  parameter logic [15:0] ADDR_EMU_CONTROL  = 16'h0041,
  parameter logic [3:0]  FRAME_HEADER      = 4'b1000,
  parameter int unsigned TIMEOUT_CYCLES    = 200
) (
  input  logic                         clk_100m,
  input  logic                         rst_n_syn,
  ssi_encoder_emulator_if.slave        reg_bus,
  input  logic                         ssi_c,
  output logic                         ssi_d,
  output logic [31:0]                  emu_position_reg,
  output logic [31:0]                  emu_control_reg,
  output logic [15:0]                  frame_cnt,
  output logic [7:0]                   abort_cnt,
  output logic                         busy
);

  localparam int unsigned FRAME_W     = 44;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned CRC_W       = 6;
  localparam int unsigned MSG_W       = 34;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned ABORT_CNT_W = 8;
  localparam int unsigned TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_ERR    = 1;
  localparam int unsigned CTRL_WARN   = 2;
  localparam int unsigned CTRL_INJECT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MONO  = 2'd2
  } state_t;

  // 6-bit CRC, poly x^6+x+1, init 0, message fed MSB first
  function automatic logic [CRC_W-1:0] crc6(input logic [MSG_W-1:0] msg);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    for (int i = int'(MSG_W) - 1; i >= 0; i--) begin
      fb = c[5] ^ msg[i];
      c  = {c[4:1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  logic ssi_meta;
  logic ssi_sync;
  logic ssi_dly;
  logic fall_c;
  logic rise_c;

  logic [TIMER_W-1:0] timer;
  logic               timeout_c;

  logic wr_pos_c;
  logic wr_ctrl_c;
  logic enable_c;
  logic start_c;
  logic abort_c;

  logic [MSG_W-1:0]   msg_c;
  logic [CRC_W-1:0]   crc_tx_c;
  logic [FRAME_W-1:0] frame_c;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       bit_idx;
  logic [IDX_W-1:0]       bit_idx_nxt;
  logic [FRAME_W-1:0]     frame_q;
  logic [FRAME_W-1:0]     frame_nxt;
  logic                   ssi_d_nxt;
  logic                   busy_nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt_nxt;
  logic [ABORT_CNT_W-1:0] abort_cnt_nxt;

  // Two-flop synchroniser for the asynchronous master clock, plus a delay flop for edge detection
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      ssi_meta <= 1'b0;
      ssi_sync <= 1'b0;
      ssi_dly  <= 1'b0;
    end else begin
      ssi_meta <= ssi_c;
      ssi_sync <= ssi_meta;
      ssi_dly  <= ssi_sync;
    end
  end

  assign fall_c = ssi_dly & ~ssi_sync;
  assign rise_c = ~ssi_dly & ssi_sync;

  // Monoflop timer: cycles ssi_c has been high since the last falling edge, saturating at the timeout
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      timer <= '0;
    end else if (fall_c) begin
      timer <= '0;
    end else if (ssi_sync && !timeout_c) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign timeout_c = (timer >= TIMER_W'(TIMEOUT_CYCLES));

  assign wr_pos_c  = reg_bus.data_mosi_rdy && (reg_bus.addr == ADDR_EMU_POSITION);
  assign wr_ctrl_c = reg_bus.data_mosi_rdy && (reg_bus.addr == ADDR_EMU_CONTROL);
  assign enable_c  = emu_control_reg[CTRL_ENABLE];

  // Register file; the one-shot CRC-corruption request clears once a frame has captured it
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      emu_position_reg <= '0;
      emu_control_reg  <= '0;
    end else begin
      if (wr_pos_c) begin
        emu_position_reg <= reg_bus.data_mosi;
      end
      if (wr_ctrl_c) begin
        emu_control_reg <= reg_bus.data_mosi;
      end else if (start_c) begin
        emu_control_reg[CTRL_INJECT] <= 1'b0;
      end
    end
  end

  // Frame image built from the live registers; captured only at frame start
  always_comb begin
    msg_c       = {emu_position_reg, emu_control_reg[CTRL_ERR], emu_control_reg[CTRL_WARN]};
    crc_tx_c    = ~crc6(msg_c);
    crc_tx_c[0] = crc_tx_c[0] ^ emu_control_reg[CTRL_INJECT];
    frame_c     = {FRAME_HEADER, msg_c, crc_tx_c};
  end

  // Frame state register and line/counter outputs
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      state     <= IDLE;
      bit_idx   <= '0;
      frame_q   <= '0;
      ssi_d     <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      frame_q   <= frame_nxt;
      ssi_d     <= ssi_d_nxt;
      busy      <= busy_nxt;
      frame_cnt <= frame_cnt_nxt;
      abort_cnt <= abort_cnt_nxt;
    end
  end

  // Next-state logic: start on falling edge, shift on rising edges, hold low until the monoflop expires
  always_comb begin
    state_nxt     = state;
    bit_idx_nxt   = bit_idx;
    frame_nxt     = frame_q;
    ssi_d_nxt     = ssi_d;
    busy_nxt      = busy;
    frame_cnt_nxt = frame_cnt;
    abort_cnt_nxt = abort_cnt;
    start_c       = 1'b0;
    abort_c       = 1'b0;

    case (state)
      IDLE: begin
        ssi_d_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (fall_c && enable_c) begin
          start_c     = 1'b1;
          frame_nxt   = frame_c;
          bit_idx_nxt = IDX_W'(FRAME_W);
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (!enable_c || timeout_c) begin
          abort_c = 1'b1;
        end else if (rise_c) begin
          if (bit_idx == '0) begin
            // Rising edge after bit 0 was sampled: frame delivered, enter monoflop
            ssi_d_nxt = 1'b0;
            state_nxt = MONO;
          end else begin
            ssi_d_nxt   = frame_q[bit_idx - IDX_W'(1)];
            bit_idx_nxt = bit_idx - IDX_W'(1);
          end
        end
      end

      MONO: begin
        ssi_d_nxt = 1'b0;
        if (!enable_c) begin
          abort_c = 1'b1;
        end else if (timeout_c) begin
          ssi_d_nxt     = 1'b1;
          busy_nxt      = 1'b0;
          frame_cnt_nxt = frame_cnt + FRAME_CNT_W'(1);
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (abort_c) begin
      ssi_d_nxt = 1'b1;
      busy_nxt  = 1'b0;
      state_nxt = IDLE;
      if (abort_cnt != '1) begin
        abort_cnt_nxt = abort_cnt + ABORT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ssi_encoder_emulator.sv
// Bench for ssi_encoder_emulator: acts as SSI master and SPI writer, checks against a CRC/frame model.
module tb_ssi_encoder_emulator;

  localparam int ACT_NONE = 0;
  localparam int ACT_POS  = 1;
  localparam int ACT_CTRL = 2;
  localparam int ACT_HOLD = 3;
  localparam int ACT_RST  = 4;

  localparam logic [15:0] A_POS  = 16'h0040;
  localparam logic [15:0] A_CTRL = 16'h0041;

  logic        clk_100m;
  logic        rst_n_syn;
  logic        ssi_c;
  logic        ssi_d;
  logic [31:0] emu_position_reg;
  logic [31:0] emu_control_reg;
  logic [15:0] frame_cnt;
  logic [7:0]  abort_cnt;
  logic        busy;

  ssi_encoder_emulator_if bus ();

  ssi_encoder_emulator dut (
    .clk_100m         (clk_100m),
    .rst_n_syn        (rst_n_syn),
    .reg_bus          (bus),
    .ssi_c            (ssi_c),
    .ssi_d            (ssi_d),
    .emu_position_reg (emu_position_reg),
    .emu_control_reg  (emu_control_reg),
    .frame_cnt        (frame_cnt),
    .abort_cnt        (abort_cnt),
    .busy             (busy)
  );

  int   n_checks;
  int   n_pass;
  bit   expect_idle;
  logic got_q[$];
  logic exp_q[$];
  logic cmp_g;
  logic cmp_e;

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference CRC as polynomial remainder of msg * x^6 modulo x^6+x+1
  function automatic logic [5:0] model_crc(input logic [33:0] msg);
    logic [39:0] v;
    v = {msg, 6'b0};
    for (int b = 39; b >= 6; b--) begin
      if (v[b]) v = v ^ (40'h43 << (b - 6));
    end
    return v[5:0];
  endfunction

  function automatic logic [43:0] model_frame(input logic [31:0] pos, input logic err,
                                              input logic warn, input logic inj);
    logic [5:0] tx;
    tx    = ~model_crc({pos, err, warn});
    tx[0] = tx[0] ^ inj;
    return {4'b1000, pos, err, warn, tx};
  endfunction

  task automatic master_decode(input logic [43:0] f, output logic [31:0] p,
                               output logic e, output logic w, output logic ok);
    p  = f[39:8];
    e  = f[7];
    w  = f[6];
    ok = (f[43:40] == 4'b1000) && ((~f[5:0]) == model_crc(f[39:6]));
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk_100m);
    bus.addr          = a;
    bus.data_mosi     = d;
    bus.data_mosi_rdy = 1'b1;
    @(negedge clk_100m);
    bus.data_mosi_rdy = 1'b0;
  endtask

  // One SSI read: fall, 44 x (rise, sample on fall), final rise; optional action after rise act_at
  task automatic ssi_read(input logic [43:0] exp, input int ones_from, input int act_at,
                          input int act, input logic [31:0] act_val, input bit full,
                          output logic [43:0] got);
    int half;
    bit early;
    int lat;
    half  = int'($urandom_range(16, 13));
    got   = '1;
    early = 1'b0;
    lat   = 0;
    @(negedge clk_100m);
    if (ones_from > 1) expect_idle = 1'b0;
    ssi_c = 1'b0;
    repeat (half) @(negedge clk_100m);
    for (int i = 1; i <= 44; i++) begin
      ssi_c = 1'b1;
      repeat (8) @(negedge clk_100m);
      if (i == act_at) begin
        if (act == ACT_POS) bus_write(A_POS, act_val);
        else if (act == ACT_CTRL) bus_write(A_CTRL, act_val);
        else if (act == ACT_HOLD) begin
          repeat (300) @(negedge clk_100m);
          early = 1'b1;
        end else if (act == ACT_RST) begin
          #2 rst_n_syn = 1'b0;
          #1;
          chk("rst_async_ssi_d", 64'(ssi_d), 64'd1);
          chk("rst_async_busy", 64'(busy), 64'd0);
          chk("rst_async_pos", 64'(emu_position_reg), 64'd0);
          chk("rst_async_ctrl", 64'(emu_control_reg), 64'd0);
          chk("rst_async_frames", 64'(frame_cnt), 64'd0);
          chk("rst_async_aborts", 64'(abort_cnt), 64'd0);
          repeat (3) @(negedge clk_100m);
          rst_n_syn = 1'b1;
          early = 1'b1;
        end
      end
      if (early) break;
      repeat (half - 8) @(negedge clk_100m);
      got[44-i] = ssi_d;
      got_q.push_back(ssi_d);
      exp_q.push_back((i >= ones_from) ? 1'b1 : exp[44-i]);
      ssi_c = 1'b0;
      repeat (half) @(negedge clk_100m);
    end
    if (!early) begin
      ssi_c = 1'b1;
      for (int n = 1; n <= 400; n++) begin
        @(negedge clk_100m);
        if (full && n == 10) chk("mono_low", 64'(ssi_d), 64'd0);
        if (full && busy === 1'b0) begin
          lat = n;
          break;
        end
        if (!full && n == 6) break;
      end
      if (full) begin
        // 200-cycle monoflop plus the 3-cycle input path from the pin
        chk("end_latency", 64'(lat >= 200 && lat <= 204), 64'd1);
        chk("end_ssi_d_high", 64'(ssi_d), 64'd1);
      end
    end
    expect_idle = 1'b1;
  endtask

  // Compare process: sampled bits against the model, idle line state whenever no frame is expected
  always @(negedge clk_100m) begin
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      cmp_g = got_q.pop_front();
      cmp_e = exp_q.pop_front();
      chk("ssi_bit", 64'(cmp_g), 64'(cmp_e));
    end
    if (expect_idle) chk("idle_lines", 64'({ssi_d, busy}), 64'(2'b10));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [43:0] got;
    logic [31:0] p;
    logic [31:0] p1;
    logic        e;
    logic        w;
    logic        ok;
    int          exp_frames;
    int          exp_aborts;
    int          crc_errs;
    int          crc_base;

    n_checks          = 0;
    n_pass            = 0;
    expect_idle       = 1'b0;
    exp_frames        = 0;
    exp_aborts        = 0;
    crc_errs          = 0;
    rst_n_syn         = 1'b0;
    ssi_c             = 1'b1;
    bus.addr          = '0;
    bus.data_mosi     = '0;
    bus.data_mosi_rdy = 1'b0;

    repeat (3) @(negedge clk_100m);
    chk("reset_ssi_d", 64'(ssi_d), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pos", 64'(emu_position_reg), 64'd0);
    chk("reset_ctrl", 64'(emu_control_reg), 64'd0);
    chk("reset_frames", 64'(frame_cnt), 64'd0);
    chk("reset_aborts", 64'(abort_cnt), 64'd0);
    rst_n_syn = 1'b1;
    repeat (3) @(negedge clk_100m);
    expect_idle = 1'b1;

    // Hand-derived frames pin the model
    chk("model_zero", 64'(model_frame(32'h0, 1'b0, 1'b0, 1'b0)), 64'h800_0000_003F);
    chk("model_warn", 64'(model_frame(32'h0, 1'b0, 1'b1, 1'b0)), 64'h800_0000_007C);
    chk("model_err", 64'(model_frame(32'h0, 1'b1, 1'b0, 1'b0)), 64'h800_0000_00B9);

    // All-zero position frame
    bus_write(A_POS, 32'h0);
    bus_write(A_CTRL, 32'h1);
    ssi_read(model_frame(32'h0, 1'b0, 1'b0, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    chk("zero_frame", 64'(got), 64'h800_0000_003F);
    chk("zero_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Loopback decode, err set and warn clear
    bus_write(A_POS, 32'h1234_5678);
    bus_write(A_CTRL, 32'h3);
    ssi_read(model_frame(32'h1234_5678, 1'b1, 1'b0, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    master_decode(got, p, e, w, ok);
    chk("lb_pos", 64'(p), 64'h1234_5678);
    chk("lb_err", 64'(e), 64'd1);
    chk("lb_warn", 64'(w), 64'd0);
    chk("lb_crc_ok", 64'(ok), 64'd1);

    // Random positions and flags
    for (int k = 0; k < 24; k++) begin
      p1 = $urandom;
      e  = 1'($urandom_range(1, 0));
      w  = 1'($urandom_range(1, 0));
      bus_write(A_POS, p1);
      bus_write(A_CTRL, {29'b0, w, e, 1'b1});
      ssi_read(model_frame(p1, e, w, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
      exp_frames++;
      master_decode(got, p, e, w, ok);
      if (!ok) crc_errs++;
    end
    chk("rand_crc_errs", 64'(crc_errs), 64'd0);
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // One-shot CRC corruption
    crc_base = crc_errs;
    bus_write(A_POS, 32'hCAFE_0001);
    bus_write(A_CTRL, 32'h9);
    ssi_read(model_frame(32'hCAFE_0001, 1'b0, 1'b0, 1'b1), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    master_decode(got, p, e, w, ok);
    if (!ok) crc_errs++;
    chk("inject_first_bad", 64'(crc_errs - crc_base), 64'd1);
    chk("inject_selfclear", 64'(emu_control_reg), 64'h1);
    ssi_read(model_frame(32'hCAFE_0001, 1'b0, 1'b0, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    master_decode(got, p, e, w, ok);
    if (!ok) crc_errs++;
    chk("inject_second_good", 64'(crc_errs - crc_base), 64'd1);

    // Master stalls high after the 10th rising edge
    ssi_read(model_frame(32'hCAFE_0001, 1'b0, 1'b0, 1'b0), 45, 10, ACT_HOLD, 32'h0, 1'b0, got);
    exp_aborts++;
    chk("stall_aborts", 64'(abort_cnt), 64'(exp_aborts));
    chk("stall_frames", 64'(frame_cnt), 64'(exp_frames));
    chk("stall_ssi_d", 64'(ssi_d), 64'd1);
    ssi_read(model_frame(32'hCAFE_0001, 1'b0, 1'b0, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    chk("after_stall_frames", 64'(frame_cnt), 64'(exp_frames));

    // Disabled: line stays high, counters hold
    bus_write(A_CTRL, 32'h0);
    ssi_read(44'h0, 1, 0, ACT_NONE, 32'h0, 1'b0, got);
    chk("disabled_line", 64'(got), 64'hFFF_FFFF_FFFF);
    chk("disabled_frames", 64'(frame_cnt), 64'(exp_frames));
    chk("disabled_aborts", 64'(abort_cnt), 64'(exp_aborts));

    // Position written mid-frame only affects the next frame
    p1 = $urandom;
    bus_write(A_POS, p1);
    bus_write(A_CTRL, 32'h1);
    ssi_read(model_frame(p1, 1'b0, 1'b0, 1'b0), 45, 20, ACT_POS, 32'hAAAA_5555, 1'b1, got);
    exp_frames++;
    chk("midwrite_reg", 64'(emu_position_reg), 64'hAAAA_5555);
    ssi_read(model_frame(32'hAAAA_5555, 1'b0, 1'b0, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    master_decode(got, p, e, w, ok);
    chk("midwrite_next_pos", 64'(p), 64'hAAAA_5555);

    // Enable cleared mid-frame aborts at once
    ssi_read(model_frame(32'hAAAA_5555, 1'b0, 1'b0, 1'b0), 20, 20, ACT_CTRL, 32'h0, 1'b0, got);
    exp_aborts++;
    chk("disable_abort_cnt", 64'(abort_cnt), 64'(exp_aborts));
    chk("disable_abort_frames", 64'(frame_cnt), 64'(exp_frames));

    // Reset mid-frame
    bus_write(A_CTRL, 32'h1);
    ssi_read(model_frame(32'hAAAA_5555, 1'b0, 1'b0, 1'b0), 45, 20, ACT_RST, 32'h0, 1'b0, got);
    exp_frames = 0;
    exp_aborts = 0;
    repeat (3) @(negedge clk_100m);
    chk("post_rst_frames", 64'(frame_cnt), 64'(exp_frames));
    chk("post_rst_aborts", 64'(abort_cnt), 64'(exp_aborts));

    // Clean frame after reset
    bus_write(A_POS, 32'h0BAD_F00D);
    bus_write(A_CTRL, 32'h5);
    ssi_read(model_frame(32'h0BAD_F00D, 1'b0, 1'b1, 1'b0), 45, 0, ACT_NONE, 32'h0, 1'b1, got);
    exp_frames++;
    chk("final_frames", 64'(frame_cnt), 64'(exp_frames));

    repeat (4) @(negedge clk_100m);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
